alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Sequential driver for the 32-bit combinational ALU. It accepts decoded instruction fields (ALUOp, funct) and two operands through a valid/ready handshake, and drives the registered operands and 4-bit ALU selector. It holds them stable for the required number of cycles: multi-cycle for MUL/DIV, which are timed as multicycle paths. It strobes `res_valid` in the cycle the ALU output (`salida`) is to be captured. It sits between the decode stage and the ALU in the datapath.

## Interface
Parameters:
- MUL_CYCLES, 2, cycles `selector`/operands are held for MUL; legal range 1..15
- DIV_CYCLES, 4, cycles held for DIV; legal range 1..15

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready at a rising edge
- alu_op  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type by funct, 11 pass Data2
- funct  in  6  MIPS funct field; used only when alu_op=10
- op_a  in  32  first operand
- op_b  in  32  second operand
- Data1  out  32  registered operand A to ALU
- Data2  out  32  registered operand B to ALU
- selector  out  4  registered ALU selector
- res_valid  out  1  capture `salida` this cycle
- busy  out  1  an operation is being held
- illegal  out  1  registered; unknown funct for the current operation
- div_zero  out  1  registered; DIV with op_b=0 for the current operation

## Operation
- Decode (alu_op, funct → selector):
  - 00 → 0010
  - 01 → 0110
  - 11 → 1111
  - 10:
    - 100000 → 0010
    - 100010 → 0110
    - 100100 → 0000
    - 100101 → 0001
    - 100110 → 0101
    - 100111 → 1100
    - 101010 → 0111
    - 011000 → 1000 (MUL)
    - 011010 → 1010 (DIV)
    - other → 1111 with illegal=1
- Latency L:
  - MUL: MUL_CYCLES
  - DIV with op_b≠0: DIV_CYCLES
  - all others: 1
- DIV with op_b=0: selector forced to 1111 (ALU passes Data2, result 0), div_zero=1, L=1.
- States:
  - IDLE (busy=0).
  - EXEC (busy=1) with 4-bit down-counter `cnt`.
- On accept:
  - Data1/Data2/selector/illegal/div_zero are loaded.
  - cnt is loaded with L-1.
  - State goes to EXEC.
- In EXEC:
  - If cnt≠0, cnt decrements.
  - If cnt=0, res_valid=1. Then: on a simultaneous accept, reload and stay in EXEC; otherwise go to IDLE.
- in_ready = !busy || (cnt==0): back-to-back single-cycle ops run at full rate.
- Data1, Data2, selector, illegal and div_zero change only on accept. They stay stable throughout EXEC and hold their last values in IDLE.
- in_valid without in_ready: the request is not taken. Upstream must hold its inputs; the block stores nothing.

## Timing
- Reset (async assert, sync release):
  - Data1=0, Data2=0, selector=0010
  - res_valid=0, busy=0, illegal=0, div_zero=0, cnt=0
  - state IDLE, in_ready=1 after release
- Accept at edge T. Outputs are valid after T. res_valid is high in cycle T+L-1 to T+L, i.e. the L-th cycle after the accept edge, for exactly one cycle per operation.
- res_valid, in_ready and busy are combinational from state/cnt only; there is no input→output combinational path.
- Reset asserted mid-EXEC aborts the operation immediately, with no res_valid. The first accept after release behaves as from IDLE.
- Each accepted request produces exactly one res_valid, in acceptance order.

## Test plan
- Reset, then funct 100000 with op_a=5, op_b=7, alu_op=10 → after accept: selector=0010, Data1=5, Data2=7; res_valid high 1 cycle later; in_ready stays 1.
- Back-to-back stream (add, sub, and, slt) with in_valid held high → one accept per cycle; selectors 0010, 0110, 0000, 0111 in successive cycles; 4 res_valid pulses.
- MUL (funct 011000, op_a=3, op_b=4), default params → busy for 2 cycles, in_ready=0 for the first, res_valid in the 2nd; selector=1000 is held for both cycles.
- DIV 100/7 then DIV 9/0 → first: selector=1010, res_valid after 4 cycles. Second: selector=1111, div_zero=1, res_valid after 1 cycle.
- funct 111111 with alu_op=10 → selector=1111, illegal=1, L=1. Next legal op clears illegal.
- DIV accepted, rst_n pulled low 2 cycles later → all outputs at reset values asynchronously; no res_valid appears after release.

Source files
------------

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - decode-side request and ALU-side operand/selector bundle for alu_issue_ctrl
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] Data1;
  logic [31:0] Data2;
  logic [3:0]  selector;
  logic        res_valid;
  logic        busy;
  logic        illegal;
  logic        div_zero;

  modport master (
    output in_valid, alu_op, funct, op_a, op_b,
    input  in_ready, Data1, Data2, selector, res_valid, busy, illegal, div_zero
  );

  modport slave (
    input  in_valid, alu_op, funct, op_a, op_b,
    output in_ready, Data1, Data2, selector, res_valid, busy, illegal, div_zero
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - registers ALU operands/selector and holds them for the op latency
module alu_issue_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);
  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [3:0] MUL_LAT_M1 = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LAT_M1 = 4'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data1_q, data1_d;
  logic [31:0] data2_q, data2_d;
  logic [3:0]  sel_q, sel_d;
  logic        illegal_q, illegal_d;
  logic        div_zero_q, div_zero_d;

  logic [3:0]  dec_sel;
  logic        dec_ill;
  logic        dec_mul;
  logic        dec_div;
  logic        dec_dz;
  logic [3:0]  dec_lat_m1;
  logic        res_valid;
  logic        busy;
  logic        in_ready;
  logic        accept;

  always_comb begin
    dec_sel = 4'b1111;
    dec_ill = 1'b0;
    dec_mul = 1'b0;
    dec_div = 1'b0;
    case (bus.alu_op)
      2'b00: dec_sel = 4'b0010;
      2'b01: dec_sel = 4'b0110;
      2'b11: dec_sel = 4'b1111;
      default: begin
        case (bus.funct)
          6'b100000: dec_sel = 4'b0010;
          6'b100010: dec_sel = 4'b0110;
          6'b100100: dec_sel = 4'b0000;
          6'b100101: dec_sel = 4'b0001;
          6'b100110: dec_sel = 4'b0101;
          6'b100111: dec_sel = 4'b1100;
          6'b101010: dec_sel = 4'b0111;
          6'b011000: begin dec_sel = 4'b1000; dec_mul = 1'b1; end
          6'b011010: begin dec_sel = 4'b1010; dec_div = 1'b1; end
          default:   begin dec_sel = 4'b1111; dec_ill = 1'b1; end
        endcase
      end
    endcase
    // Divide by zero is demoted to a single-cycle pass of Data2 (which is 0).
    dec_dz = dec_div && (bus.op_b == 32'd0);
    if (dec_dz) dec_sel = 4'b1111;
    if (dec_mul)                 dec_lat_m1 = MUL_LAT_M1;
    else if (dec_div && !dec_dz) dec_lat_m1 = DIV_LAT_M1;
    else                         dec_lat_m1 = 4'd0;
  end

  assign busy      = (state_q == EXEC);
  assign res_valid = busy && (cnt_q == 4'd0);
  assign in_ready  = !busy || (cnt_q == 4'd0);
  assign accept    = bus.in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    sel_d      = sel_q;
    illegal_d  = illegal_q;
    div_zero_d = div_zero_q;
    if (state_q == EXEC) begin
      if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else               state_d = IDLE;
    end
    if (accept) begin
      state_d    = EXEC;
      cnt_d      = dec_lat_m1;
      data1_d    = bus.op_a;
      data2_d    = bus.op_b;
      sel_d      = dec_sel;
      illegal_d  = dec_ill;
      div_zero_d = dec_dz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      data1_q    <= 32'd0;
      data2_q    <= 32'd0;
      sel_q      <= 4'b0010;
      illegal_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      sel_q      <= sel_d;
      illegal_q  <= illegal_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.res_valid = res_valid;
  assign bus.busy      = busy;
  assign bus.Data1     = data1_q;
  assign bus.Data2     = data2_q;
  assign bus.selector  = sel_q;
  assign bus.illegal   = illegal_q;
  assign bus.div_zero  = div_zero_q;
endmodule
